// File: rtl/event_rate_counters.sv
// Multi-channel event-rate meter. Counts synchronised rising edges per channel over a
// gate of 2^gateLog2 seconds, timed by an external PPS or by an internal 1 s timebase
// when a watchdog reports the external marker missing. Results are read one channel
// at a time through a registered status word.
module event_rate_counters #(
    parameter int unsigned NC          = 4,
    parameter int unsigned CLK_RATE    = 100000000,
    parameter int unsigned COUNT_WIDTH = 29
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          csrStrobe,
    input  logic [31:0]   GPIO_OUT,
    output logic [31:0]   status,
    input  logic [NC-1:0] eventMarkers_a,
    input  logic          ppsMarker_a,
    output logic          ppsStrobe,
    output logic          gateDone
);

    localparam int unsigned SEL       = (NC > 1) ? $clog2(NC) : 1;
    // One spare MSB on both down-counters serves as the underflow / timeout flag.
    localparam int unsigned TW        = $clog2(CLK_RATE) + 1;
    localparam int unsigned WD_RELOAD = (CLK_RATE / 10) * 11 - 2;
    localparam int unsigned WW        = $clog2(WD_RELOAD + 2) + 1;

    localparam logic [TW-1:0]          TICK_RELOAD = TW'(CLK_RATE - 2);
    localparam logic [WW-1:0]          WD_LOAD     = WW'(WD_RELOAD);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);

    // Timebase, PPS path and watchdog
    logic [TW-1:0] ticks_q, ticks_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          pps_m_q, pps_m_d;
    logic          pps_d0_q, pps_d0_d;
    logic          pps_d1_q, pps_d1_d;
    logic          pps_ext_q, pps_ext_d;
    logic          pps_strobe_q, pps_strobe_d;
    logic          internal_strobe;
    logic          use_internal;

    // Configuration and gate control
    logic [SEL-1:0] select_q, select_d;
    logic [2:0]     gate_log2_q, gate_log2_d;
    logic           force_internal_q, force_internal_d;
    logic           armed_q, armed_d;
    logic [7:0]     gate_count_q, gate_count_d;
    logic [7:0]     gate_last;
    logic           gate_end;
    logic           restart;
    logic           cfg_wr;
    logic           sel_wr;
    logic           valid_q, valid_d;
    logic           used_internal_q, used_internal_d;
    logic           gate_done_q, gate_done_d;

    // Per-channel state
    logic [NC-1:0]          ev_s0_q, ev_s0_d;
    logic [NC-1:0]          ev_s1_q, ev_s1_d;
    logic [NC-1:0]          ev_s2_q, ev_s2_d;
    logic [NC-1:0]          ev_rise_q, ev_rise_d;
    logic [NC-1:0]          sticky_q, sticky_d;
    logic [COUNT_WIDTH-1:0] acc_q [NC];
    logic [COUNT_WIDTH-1:0] acc_d [NC];
    logic [COUNT_WIDTH-1:0] res_q [NC];
    logic [COUNT_WIDTH-1:0] res_d [NC];

    // Readout
    logic [31:0]            status_q, status_d;
    logic [COUNT_WIDTH-1:0] sel_res;
    logic                   sel_sticky;
    logic [28:0]            res_ext;
    logic                   unused_gpio;

    assign unused_gpio = ^GPIO_OUT;

    // Internal second, PPS edge detection, watchdog and gating-marker selection.
    always_comb begin
        internal_strobe = ticks_q[TW-1];
        ticks_d         = internal_strobe ? TICK_RELOAD : ticks_q - TW'(1);

        pps_m_d   = ppsMarker_a;
        pps_d0_d  = pps_m_q;
        pps_d1_d  = pps_d0_q;
        pps_ext_d = pps_d0_q & ~pps_d1_q;

        if (pps_ext_q) begin
            wd_d = WD_LOAD;
        end else if (wd_q[WW-1]) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q - WW'(1);
        end

        use_internal = wd_q[WW-1] | force_internal_q;
        pps_strobe_d = use_internal ? internal_strobe : pps_ext_q;
    end

    // Gate sequencing, CSR decode and per-channel edge accumulation.
    always_comb begin
        cfg_wr    = csrStrobe & GPIO_OUT[31];
        sel_wr    = csrStrobe & ~GPIO_OUT[31];
        gate_last = (8'd1 << gate_log2_q) - 8'd1;
        gate_end  = pps_strobe_q & armed_q & (gate_count_q == gate_last);
        // Arming and latching both start a fresh accumulation window.
        restart   = pps_strobe_q & (~armed_q | gate_end);

        armed_d          = armed_q;
        gate_count_d     = gate_count_q;
        gate_log2_d      = gate_log2_q;
        force_internal_d = force_internal_q;
        select_d         = select_q;
        valid_d          = valid_q | gate_end;
        gate_done_d      = gate_end;
        used_internal_d  = pps_strobe_q ? use_internal : used_internal_q;

        if (pps_strobe_q) begin
            if (!armed_q) begin
                armed_d      = 1'b1;
                gate_count_d = 8'd0;
            end else if (gate_end) begin
                gate_count_d = 8'd0;
            end else begin
                gate_count_d = gate_count_q + 8'd1;
            end
        end

        if (cfg_wr) begin
            gate_log2_d      = GPIO_OUT[2:0];
            force_internal_d = GPIO_OUT[3];
            armed_d          = 1'b0;
        end
        if (sel_wr) begin
            select_d = GPIO_OUT[SEL-1:0];
        end

        ev_s0_d   = eventMarkers_a;
        ev_s1_d   = ev_s0_q;
        ev_s2_d   = ev_s1_q;
        ev_rise_d = ev_s1_q & ~ev_s2_q;

        sticky_d = sticky_q;
        acc_d    = acc_q;
        res_d    = res_q;
        for (int unsigned i = 0; i < NC; i++) begin
            if (sel_wr && GPIO_OUT[30] && (GPIO_OUT[SEL-1:0] == SEL'(i))) begin
                sticky_d[i] = 1'b0;
            end
            if (gate_end) begin
                res_d[i] = acc_q[i];
            end
            if (restart) begin
                // A coincident edge belongs to the gate that is starting.
                acc_d[i] = ev_rise_q[i] ? CNT_ONE : '0;
            end else if (ev_rise_q[i]) begin
                if (acc_q[i] == CNT_MAX) begin
                    sticky_d[i] = 1'b1;
                end else begin
                    acc_d[i] = acc_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Status word for the selected channel; out-of-range selects read as zero.
    always_comb begin
        sel_res    = '0;
        sel_sticky = 1'b0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (select_q == SEL'(i)) begin
                sel_res    = res_q[i];
                sel_sticky = sticky_q[i];
            end
        end
        res_ext                    = '0;
        res_ext[COUNT_WIDTH-1:0]   = sel_res;
        status_d                   = {used_internal_q, sel_sticky, valid_q, res_ext};
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ticks_q          <= TICK_RELOAD;
            wd_q             <= '1;
            pps_m_q          <= 1'b0;
            pps_d0_q         <= 1'b0;
            pps_d1_q         <= 1'b0;
            pps_ext_q        <= 1'b0;
            pps_strobe_q     <= 1'b0;
            select_q         <= '0;
            gate_log2_q      <= 3'd0;
            force_internal_q <= 1'b0;
            armed_q          <= 1'b0;
            gate_count_q     <= 8'd0;
            valid_q          <= 1'b0;
            used_internal_q  <= 1'b0;
            gate_done_q      <= 1'b0;
            ev_s0_q          <= '0;
            ev_s1_q          <= '0;
            ev_s2_q          <= '0;
            ev_rise_q        <= '0;
            sticky_q         <= '0;
            acc_q            <= '{default: '0};
            res_q            <= '{default: '0};
            status_q         <= '0;
        end else begin
            ticks_q          <= ticks_d;
            wd_q             <= wd_d;
            pps_m_q          <= pps_m_d;
            pps_d0_q         <= pps_d0_d;
            pps_d1_q         <= pps_d1_d;
            pps_ext_q        <= pps_ext_d;
            pps_strobe_q     <= pps_strobe_d;
            select_q         <= select_d;
            gate_log2_q      <= gate_log2_d;
            force_internal_q <= force_internal_d;
            armed_q          <= armed_d;
            gate_count_q     <= gate_count_d;
            valid_q          <= valid_d;
            used_internal_q  <= used_internal_d;
            gate_done_q      <= gate_done_d;
            ev_s0_q          <= ev_s0_d;
            ev_s1_q          <= ev_s1_d;
            ev_s2_q          <= ev_s2_d;
            ev_rise_q        <= ev_rise_d;
            sticky_q         <= sticky_d;
            acc_q            <= acc_d;
            res_q            <= res_d;
            status_q         <= status_d;
        end
    end

    assign status    = status_q;
    assign ppsStrobe = pps_strobe_q;
    assign gateDone  = gate_done_q;

endmodule

// File: tb/tb_event_rate_counters.sv
// Directed bench for event_rate_counters: a wide instance (4 channels, 29-bit counts)
// and a narrow one (3 channels, 4-bit counts) share clock, reset, CSR and event inputs.
module tb_event_rate_counters;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_strobe;
    logic [31:0] gpio_out;
    logic        ev0 = 1'b0, ev1 = 1'b0, ev2 = 1'b0;
    logic        en0 = 1'b0, en1 = 1'b0, pps_en = 1'b0;
    logic        pps = 1'b0;
    logic [3:0]  ev;
    logic [31:0] status_a, status_b;
    logic        pps_a, pps_b, done_a, done_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    assign ev = {1'b0, ev2, ev1, ev0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    event_rate_counters #(.NC(4), .CLK_RATE(1000), .COUNT_WIDTH(29)) dut (
        .clk            (clk),
        .reset          (reset),
        .csrStrobe      (csr_strobe),
        .GPIO_OUT       (gpio_out),
        .status         (status_a),
        .eventMarkers_a (ev),
        .ppsMarker_a    (pps),
        .ppsStrobe      (pps_a),
        .gateDone       (done_a)
    );

    event_rate_counters #(.NC(3), .CLK_RATE(1000), .COUNT_WIDTH(4)) dut_s (
        .clk            (clk),
        .reset          (reset),
        .csrStrobe      (csr_strobe),
        .GPIO_OUT       (gpio_out),
        .status         (status_b),
        .eventMarkers_a (ev[2:0]),
        .ppsMarker_a    (pps),
        .ppsStrobe      (pps_b),
        .gateDone       (done_b)
    );

    // ch0: period 10 clk, ch1: period 20 clk, PPS: period 1000 clk, 5 clk high.
    initial begin : gen0
        int k;
        k = 0;
        forever begin
            @(posedge clk); #1;
            if (en0) begin ev0 = (k < 5); k = (k + 1) % 10; end
            else begin ev0 = 1'b0; k = 0; end
        end
    end

    initial begin : gen1
        int k;
        k = 0;
        forever begin
            @(posedge clk); #1;
            if (en1) begin ev1 = (k < 10); k = (k + 1) % 20; end
            else begin ev1 = 1'b0; k = 0; end
        end
    end

    initial begin : gen_pps
        int k;
        k = 0;
        forever begin
            @(posedge clk); #1;
            if (pps_en) begin pps = (k < 5); k = (k + 1) % 1000; end
            else begin pps = 1'b0; k = 0; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [31:0] d);
        csr_strobe = 1'b1;
        gpio_out   = d;
        tick();
        csr_strobe = 1'b0;
        gpio_out   = '0;
    endtask

    task automatic wait_done(input int maxc, output int cycles, output int strobes,
                             output logic seen);
        cycles  = 0;
        strobes = 0;
        seen    = 1'b0;
        while (!seen && cycles < maxc) begin
            tick();
            cycles++;
            if (pps_a) strobes++;
            if (done_a) seen = 1'b1;
        end
    endtask

    initial begin
        int   rcyc, c, s;
        logic seen;

        // Reset state
        reset = 1'b1; csr_strobe = 1'b0; gpio_out = '0;
        repeat (3) tick();
        reset = 1'b0;
        rcyc  = cyc;
        check("reset_status_a", status_a, 32'h0);
        check("reset_status_b", status_b, 32'h0);
        check("reset_done", {30'd0, done_a, done_b}, 32'h0);
        check("reset_pps", {30'd0, pps_a, pps_b}, 32'h0);

        // Internal timebase: arm on 1st strobe, latch on 2nd; ch0 = 100 per gate
        en0 = 1'b1;
        wait_done(2500, c, s, seen);
        check("int_gate_seen", {31'd0, seen}, 32'd1);
        check("int_gate_time", cyc - rcyc, 32'd2001);
        check("int_gate_strobes", s, 32'd2);
        tick();
        check("int_status_a", status_a, 32'hA000_0064);
        check("int_status_b_sat", status_b, 32'hE000_000F);
        check("done_one_cycle", {31'd0, done_a}, 32'd0);

        // Sticky clear on select write; out-of-range select reads zero
        csr_write(32'h4000_0000);
        tick();
        check("sticky_clr_b", status_b, 32'hA000_000F);
        check("sticky_clr_a", status_a, 32'hA000_0064);
        csr_write(32'h0000_0003);
        tick();
        check("sel3_a", status_a, 32'hA000_0000);
        check("sel3_b_oob", status_b, 32'hA000_0000);

        // External PPS takes over; ch1 = 50 per gate
        csr_write(32'h0000_0001);
        en1    = 1'b1;
        pps_en = 1'b1;
        for (int g = 0; g < 3; g++) begin
            wait_done(1500, c, s, seen);
            check("ext_gate_seen", {31'd0, seen}, 32'd1);
        end
        tick();
        check("ext_status_a", status_a, 32'h2000_0032);
        check("ext_status_b", status_b, 32'h6000_000F);

        // PPS stops: watchdog must hold off internal gating for ~1100 clk
        pps_en = 1'b0;
        wait_done(2500, c, s, seen);
        check("wd_gate_seen", {31'd0, seen}, 32'd1);
        check("wd_timeout_window", {31'd0, (c >= 1100 && c <= 2110)}, 32'd1);
        tick();
        check("wd_used_internal", {31'd0, status_a[31]}, 32'd1);
        wait_done(1200, c, s, seen);
        check("wd_gate2_seen", {31'd0, seen}, 32'd1);
        tick();
        check("wd_status_a", status_a, 32'hA000_0032);

        // Gate of 4 s: arm + 4 counted strobes, old result held until then
        csr_write(32'h8000_0002);
        tick();
        check("cfg_hold_a", status_a, 32'hA000_0032);
        csr_write(32'h0000_0000);
        tick();
        check("cfg_sel0_a", status_a, 32'hA000_0064);
        check("cfg_sel0_b", status_b, 32'hE000_000F);
        wait_done(5500, c, s, seen);
        check("g4_seen", {31'd0, seen}, 32'd1);
        check("g4_strobes", s, 32'd5);
        tick();
        check("g4_status_a", status_a, 32'hA000_0190);
        check("g4_status_b", status_b, 32'hE000_000F);

        // Reset mid-gate, then an edge coincident with the gate end
        repeat (300) tick();
        check("pre_reset_a", status_a, 32'hA000_0190);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        rcyc  = cyc;
        check("mid_reset_a", status_a, 32'h0);
        check("mid_reset_b", status_b, 32'h0);
        check("mid_reset_done", {31'd0, done_a}, 32'd0);
        tick();
        check("mid_reset_a_hold", status_a, 32'h0);
        csr_write(32'h0000_0002);
        while (cyc < rcyc + 1997) tick();
        ev2 = 1'b1;
        repeat (3) tick();
        ev2 = 1'b0;
        wait_done(1000, c, s, seen);
        check("coinc_seen", {31'd0, seen}, 32'd1);
        check("coinc_time", cyc - rcyc, 32'd2001);
        tick();
        check("coinc_old_gate_a", status_a, 32'hA000_0000);
        check("coinc_old_gate_b", status_b, 32'hA000_0000);
        wait_done(1200, c, s, seen);
        check("coinc2_seen", {31'd0, seen}, 32'd1);
        tick();
        check("coinc_new_gate_a", status_a, 32'hA000_0001);
        check("coinc_new_gate_b", status_b, 32'hA000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/event_rate_counters.md
Name: event_rate_counters

Overview:
Multi-channel event-rate meter for asynchronous, slow event markers such as triggers, interlock pulses and beam-loss flags. It counts rising edges per channel over a gate of 2^k seconds. The gate is timed by an external PPS marker when that marker is present, and by an internal 1 s timebase when a watchdog says it is absent. Latched results are read through the same single-word CSR select/status scheme as the frequency counters, with added gate-length configuration and sticky saturation flags.

Parameters:
NC, 4, number of event channels (1..256)
CLK_RATE, 100000000, clk frequency in Hz; sets the internal second and the watchdog
COUNT_WIDTH, 29, per-channel accumulator/result width (1..29)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
csrStrobe  in  1  one-cycle write strobe for GPIO_OUT
GPIO_OUT  in  32  CSR write data
status  out  32  readout word for the selected channel
eventMarkers_a  in  NC  asynchronous event inputs; each pulse is high ≥2 clk and low ≥2 clk
ppsMarker_a  in  1  asynchronous external PPS
ppsStrobe  out  1  one-cycle marker actually used for gating
gateDone  out  1  one-cycle strobe when results are latched

Behaviour:
- Reset and power-up values:
  - ticks = CLK_RATE-2; watchdog = all ones (timed out, so internal PPS is used).
  - select = 0, gateLog2 = 0, forceInternal = 0, armed = 0, gateCount = 0.
  - All accumulators, results and sticky flags = 0; valid = 0; usedInternal = 0.
  - ppsStrobe = 0, gateDone = 0.
- Internal timebase:
  - ticks decrements each cycle.
  - When its MSB is set it reloads to CLK_RATE-2.
  - This gives one internal strobe every CLK_RATE cycles.
- External PPS path:
  - Synchronizer chain m→d0→d1; ppsExt = d0 & !d1, registered.
  - ppsExt reloads the watchdog to (CLK_RATE/10)*11-2.
  - Otherwise the watchdog decrements until its MSB (timeout) is set, then holds.
- Marker selection:
  - useInternal = timeout | forceInternal.
  - ppsStrobe <= useInternal ? internalStrobe : ppsExt.
  - On each ppsStrobe: usedInternal <= useInternal.
- Event inputs:
  - Per channel: 2-flop synchronizer, then a rising-edge detect register.
  - Latency from the input edge to the accumulator increment is 4 clk.
- Gating:
  - ppsStrobe with armed = 0: clear accumulators, armed <= 1, gateCount <= 0. No latch.
  - ppsStrobe with armed = 1 and gateCount == 2^gateLog2 - 1:
    - results <= accumulators, gateDone = 1 in the next cycle, valid <= 1, gateCount <= 0.
    - Accumulators restart. An edge in that same cycle loads the accumulator with 1, i.e. it belongs to the new gate.
  - ppsStrobe with armed = 1, otherwise: gateCount += 1.
  - gateCount width is 8 bits.
- Arithmetic:
  - Accumulators saturate at 2^COUNT_WIDTH-1.
  - An edge arriving at the maximum sets that channel's sticky flag.
  - Results carry the saturated value.
- CSR writes, on csrStrobe:
  - GPIO_OUT[31] = 1 (config write):
    - gateLog2 <= GPIO_OUT[2:0] (gate of 1..128 s); forceInternal <= GPIO_OUT[3].
    - armed <= 0, so the next ppsStrobe re-arms. Results and valid are retained.
  - GPIO_OUT[31] = 0 (select write):
    - select <= GPIO_OUT[SEL-1:0], where SEL = max(1, clog2(NC)).
    - If GPIO_OUT[30] = 1, also clear the sticky flag of the newly selected channel.
    - If saturation and clear hit the same flag in the same cycle, set wins.
  - Select values ≥ NC read a result of 0 with sticky = 0.
- Status word:
  - status = {usedInternal, sticky[select], valid, zero-extended results[select] (29 bits)}.
  - It is registered: 1 cycle after a select change or a latch.
- Reset mid-gate: all state returns to reset values, and the partial gate is discarded.

Test Plan:
- CLK_RATE=1000, no external PPS, ch0 edge every 10 clk → after the 2nd internal strobe: gateDone, status = {1,0,1,100}.
- External PPS every 1000 clk, ch1 every 20 clk, select=1 → usedInternal=0, result 50 per gate; internal strobes are ignored.
- External PPS stops → watchdog times out 1100 clk after the last edge; subsequent gates use internal, usedInternal=1.
- Config write gateLog2=2, ch0 every 10 clk → first latch 5 PPS after the write (1 arm + 4 counted); result 400; old result/valid held meanwhile.
- COUNT_WIDTH=4, 20 edges in one gate → result 15, sticky=1; select write with bit30=1 → sticky=0, result 15 retained.
- Assert reset mid-gate; edge coincident with a gate end → status=0, valid=0 after reset; the coincident edge is counted in the next gate only.
